nx_fifo_wr_arb: RTL and testbench

- Round-robin write-port arbiter that lets N_REQ independent producers share the write side of one nx_fifo instance.
- With LOCK_PKT=1 it grants whole packets: once a producer's first beat is accepted, it holds the grant until that producer's eop beat is accepted, so packets never interleave in the FIFO.
- Sits directly in front of the shared FIFO. Drives the FIFO's wen/wdata and consumes its full flag.

---
 rtl/nx_fifo_wr_arb.sv | 110 +++++++++++
 tb/tb_nx_fifo_wr_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_wr_arb.sv
// Round-robin write-port arbiter sharing one nx_fifo among N_REQ producers.
// Ports: clk, rst_n, clear, req_valid/eop/data in, req_ready out,
//        fifo_full in, fifo_wen/fifo_wdata out, grant_idx, locked out.
module nx_fifo_wr_arb #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 263,
    parameter int LOCK_PKT = 1,
    parameter int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_eop,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wen,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   locked
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

    logic [0:0]       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] scan;
    logic [IDX_W-1:0] g;
    logic [IDX_W-1:0] nxt_ptr;
    logic [IDX_W:0]   sum;
    logic             found;
    logic             accept;
    logic             eff_eop;

    // Rotating priority scan starting at rr_ptr; falls back to rr_ptr.
    always_comb begin
        scan  = rr_ptr;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ))
                sum = sum - (IDX_W+1)'(N_REQ);
            if (!found && req_valid[sum[IDX_W-1:0]]) begin
                found = 1'b1;
                scan  = sum[IDX_W-1:0];
            end
        end
    end

    assign g       = (state == S_LOCK) ? owner : scan;
    assign eff_eop = req_eop[g] | (LOCK_PKT == 0);
    assign nxt_ptr = (g == LAST) ? '0 : g + 1'b1;
    assign accept  = req_valid[g] & ~fifo_full & ~clear & rst_n;

    // Outputs are forced low while reset is asserted, without a clock edge.
    assign grant_idx  = rst_n ? g : '0;
    assign locked     = (state == S_LOCK);
    assign fifo_wen   = accept;
    assign fifo_wdata = accept ? req_data[g*WIDTH +: WIDTH] : '0;

    // A locked owner sees ready even with valid low, so it may resume.
    always_comb begin
        req_ready = '0;
        if (rst_n && !fifo_full && !clear &&
            (state == S_LOCK || req_valid[g]))
            req_ready[g] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (clear) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (accept) begin
            if (state == S_IDLE) begin
                if (eff_eop) begin
                    rr_ptr <= nxt_ptr;
                end else begin
                    state <= S_LOCK;
                    owner <= g;
                end
            end else if (eff_eop) begin
                state  <= S_IDLE;
                rr_ptr <= nxt_ptr;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_wen && fifo_full))
                else $error("wen while fifo_full");
            assert ($onehot0(req_ready))
                else $error("req_ready not onehot0");
        end
    end
`endif

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Directed testbench for nx_fifo_wr_arb.
// Drives on negedge, checks combinational outputs #1 later.
module tb_nx_fifo_wr_arb;

    localparam int N = 4;
    localparam int W = 263;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           clear;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_eop;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           fifo_full;
    logic           fifo_wen;
    logic [W-1:0]   fifo_wdata;
    logic [1:0]     grant_idx;
    logic           locked;

    int checks   = 0;
    int failures = 0;

    nx_fifo_wr_arb #(.N_REQ(N), .WIDTH(W), .LOCK_PKT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_eop    (req_eop),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .grant_idx  (grant_idx),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dv(int i, int b);
        logic [W-1:0] d;
        d        = '0;
        d[W-1]   = 1'b1;
        d[15:8]  = 8'(i);
        d[7:0]   = 8'(b);
        return d;
    endfunction

    task automatic load(int b);
        for (int i = 0; i < N; i++)
            req_data[i*W +: W] = dv(i, b);
    endtask

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(logic [N-1:0] v, logic [N-1:0] e, int b);
        @(negedge clk);
        req_valid = v;
        req_eop   = e;
        load(b);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        req_valid = '0;
        req_eop   = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_wen", W'(fifo_wen), W'(0));
        chk("rst_gnt", W'(grant_idx), W'(0));
        chk("rst_lock", W'(locked), W'(0));
        chk("rst_rdy", W'(req_ready), W'(0));

        // Round robin, single-beat packets.
        for (int c = 0; c < 8; c++) begin
            step(4'b1111, 4'b1111, c);
            chk("rr_gnt", W'(grant_idx), W'(c % 4));
            chk("rr_wen", W'(fifo_wen), W'(1));
            chk("rr_data", fifo_wdata, dv(c % 4, c));
            chk("rr_rdy", W'(req_ready), W'(1 << (c % 4)));
        end

        // Req1 3-beat packet, req2 waiting.
        step(4'b0110, 4'b0100, 10);
        chk("p3_b1_gnt", W'(grant_idx), W'(1));
        chk("p3_b1_data", fifo_wdata, dv(1, 10));
        chk("p3_b1_lock", W'(locked), W'(0));
        step(4'b0110, 4'b0100, 11);
        chk("p3_b2_lock", W'(locked), W'(1));
        chk("p3_b2_data", fifo_wdata, dv(1, 11));
        step(4'b0110, 4'b0110, 12);
        chk("p3_b3_lock", W'(locked), W'(1));
        chk("p3_b3_data", fifo_wdata, dv(1, 12));
        step(4'b0100, 4'b0100, 13);
        chk("p3_r2_gnt", W'(grant_idx), W'(2));
        chk("p3_r2_data", fifo_wdata, dv(2, 13));
        chk("p3_r2_lock", W'(locked), W'(0));
        step(4'b0000, 4'b0000, 14);
        chk("p3_ptr3", W'(grant_idx), W'(3));
        chk("p3_idle_wen", W'(fifo_wen), W'(0));

        // Owner req0 stalls two cycles, req3 must wait.
        step(4'b0001, 4'b0000, 20);
        chk("st_b1_gnt", W'(grant_idx), W'(0));
        chk("st_b1_data", fifo_wdata, dv(0, 20));
        for (int c = 0; c < 2; c++) begin
            step(4'b1000, 4'b1000, 21 + c);
            chk("st_gap_wen", W'(fifo_wen), W'(0));
            chk("st_gap_gnt", W'(grant_idx), W'(0));
            chk("st_gap_rdy", W'(req_ready), W'(4'b0001));
            chk("st_gap_lock", W'(locked), W'(1));
        end
        step(4'b1001, 4'b1001, 23);
        chk("st_eop_data", fifo_wdata, dv(0, 23));
        chk("st_eop_rdy", W'(req_ready), W'(4'b0001));
        step(4'b1000, 4'b1000, 24);
        chk("st_r3_gnt", W'(grant_idx), W'(3));
        chk("st_r3_data", fifo_wdata, dv(3, 24));

        // FIFO full for three cycles.
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(4'b0100, 4'b0100, 30 + c);
            chk("ff_rdy", W'(req_ready), W'(0));
            chk("ff_wen", W'(fifo_wen), W'(0));
            chk("ff_gnt", W'(grant_idx), W'(2));
            chk("ff_lock", W'(locked), W'(0));
        end
        @(negedge clk);
        fifo_full = 1'b0;
        #1;
        chk("ff_rel_wen", W'(fifo_wen), W'(1));
        chk("ff_rel_data", fifo_wdata, dv(2, 32));

        // Clear while locked on req1 (rr_ptr now 3).
        step(4'b0010, 4'b0000, 40);
        chk("cl_b1_gnt", W'(grant_idx), W'(1));
        chk("cl_b1_wen", W'(fifo_wen), W'(1));
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("cl_lock_pre", W'(locked), W'(1));
        chk("cl_wen", W'(fifo_wen), W'(0));
        chk("cl_rdy", W'(req_ready), W'(0));
        @(negedge clk);
        clear     = 1'b0;
        req_valid = '0;
        #1;
        chk("cl_post_lock", W'(locked), W'(0));
        chk("cl_post_gnt", W'(grant_idx), W'(0));

        // Re-lock on req1, then async reset mid-packet.
        step(4'b0010, 4'b0000, 50);
        chk("ar_b1_wen", W'(fifo_wen), W'(1));
        step(4'b0010, 4'b0000, 51);
        chk("ar_b2_lock", W'(locked), W'(1));
        chk("ar_b2_data", fifo_wdata, dv(1, 51));
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_wen", W'(fifo_wen), W'(0));
        chk("ar_lock", W'(locked), W'(0));
        chk("ar_rdy", W'(req_ready), W'(0));
        chk("ar_gnt", W'(grant_idx), W'(0));
        chk("ar_data", fifo_wdata, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        #1;
        chk("ar_rel_lock", W'(locked), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
